// File: rtl/s_axi_write_bram_slave_pkg.sv
// Shared AXI definitions for the AXI4-Lite write slave and the write-burst
// master: write-channel FSM state encoding and BRESP response codes.
// No ports; import with "import s_axi_write_bram_slave_pkg::*;".
package s_axi_write_bram_slave_pkg;

  // Write-channel FSM states. One transaction is in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } wr_state_e;

  // BRESP encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/s_axi_write_bram_slave.sv
// AXI4-Lite write-only slave that turns each write into a single-cycle
// byte-enabled BRAM write. Writes outside the BRAM window get SLVERR and
// leave the BRAM untouched.
//
// Ports:
//   s_axi_aclk, s_axi_areset       clock, synchronous active-high reset
//   s_axi_aw*                      write address channel (awprot ignored)
//   s_axi_w*                       write data channel
//   s_axi_b*                       write response channel
//   bram_addr/bram_wdata/bram_we   BRAM word address, data, byte enables
//   write_count                    saturating count of OKAY responses
module s_axi_write_bram_slave
  import s_axi_write_bram_slave_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_BRAM_ADDR_WIDTH  = 9,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  output logic [C_BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bram_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] bram_we,
  output logic [15:0]                     write_count
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  // Byte size of the BRAM window, one bit wider than the address so the
  // comparison cannot overflow.
  localparam logic [C_S_AXI_ADDR_WIDTH:0] SPAN =
    (C_S_AXI_ADDR_WIDTH+1)'(1) << (C_BRAM_ADDR_WIDTH + LSB);

  wr_state_e                   state, next_state;
  logic                        awready_c, wready_c;
  logic                        aw_hs, w_hs, b_hs;
  logic [C_S_AXI_ADDR_WIDTH:0] diff;
  logic                        addr_ok;
  logic                        in_range_q;
  logic [STRB_W-1:0]           wstrb_q;
  logic                        unused_awprot;

  assign unused_awprot = ^s_axi_awprot;

  // Extended subtraction: the top bit is the borrow, so addresses below the
  // base wrap to a huge value and fail the upper-bound test as well.
  assign diff    = {1'b0, s_axi_awaddr} - {1'b0, C_BASE_ADDR};
  assign addr_ok = !diff[C_S_AXI_ADDR_WIDTH] && (diff < SPAN);

  // Handshake outputs are forced low while reset is asserted, independent
  // of the state register, so nothing is accepted during reset.
  assign s_axi_awready = awready_c && !s_axi_areset;
  assign s_axi_wready  = wready_c && !s_axi_areset;
  assign s_axi_bvalid  = (state == ST_RESP) && !s_axi_areset;
  assign s_axi_bresp   = (s_axi_bvalid && !in_range_q) ? RESP_SLVERR : RESP_OKAY;
  assign bram_we       = ((state == ST_WRITE) && in_range_q && !s_axi_areset)
                         ? wstrb_q : '0;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state <= ST_IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        awready_c = 1'b1;
        wready_c  = 1'b1;
        if (aw_hs && w_hs) next_state = ST_WRITE;
        else if (aw_hs)    next_state = ST_WAIT_W;
        else if (w_hs)     next_state = ST_WAIT_AW;
      end
      ST_WAIT_W: begin
        wready_c = 1'b1;
        if (w_hs) next_state = ST_WRITE;
      end
      ST_WAIT_AW: begin
        awready_c = 1'b1;
        if (aw_hs) next_state = ST_WRITE;
      end
      ST_WRITE: next_state = ST_RESP;
      ST_RESP:  if (b_hs) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Address, range verdict, data and strobes are captured on their own
  // handshakes and then held until the next transaction replaces them.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      bram_addr   <= '0;
      bram_wdata  <= '0;
      wstrb_q     <= '0;
      in_range_q  <= 1'b0;
      write_count <= '0;
    end else begin
      if (aw_hs) begin
        bram_addr  <= diff[LSB +: C_BRAM_ADDR_WIDTH];
        in_range_q <= addr_ok;
      end
      if (w_hs) begin
        bram_wdata <= s_axi_wdata;
        wstrb_q    <= s_axi_wstrb;
      end
      if (b_hs && in_range_q && (write_count != 16'hFFFF))
        write_count <= write_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_s_axi_write_bram_slave.sv
// Self-checking bench for s_axi_write_bram_slave (base 0, 9-bit BRAM
// address, 64-bit data). Expected values come from a transaction-level
// model: window check, word index, response code and OKAY count.
module tb_s_axi_write_bram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [8:0]  bram_addr;
  logic [63:0] bram_wdata;
  logic [7:0]  bram_we;
  logic [15:0] write_count;

  int total = 0;
  int bad   = 0;
  int model_count = 0;

  // Observations filled in by run_write for the test tasks to judge.
  int          obs_hs, obs_b, obs_bcycles, stray_we;
  logic [7:0]  obs_we;
  logic [8:0]  obs_addr;
  logic [63:0] obs_wdata;
  logic [1:0]  obs_bresp;
  bit          resp_bad, wait_bad, timed_out;

  s_axi_write_bram_slave dut (
    .s_axi_aclk    (aclk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_we       (bram_we),
    .write_count   (write_count)
  );

  always #5 aclk = ~aclk;

  // Drives one transaction: AW offered from cycle aw_dly, W from w_dly,
  // bready withheld for b_hold cycles of bvalid. Inputs change #1 after a
  // rising edge; outputs are sampled on the falling edge.
  task automatic run_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int aw_dly,
                           input int w_dly, input int b_hold);
    int cyc = 0;
    int b_wait = 0;
    bit aw_done = 0, w_done = 0, done = 0, aw_now, w_now;
    obs_hs = -1; obs_b = -1; obs_bcycles = 0; stray_we = 0;
    obs_we = '0; obs_addr = '0; obs_wdata = '0; obs_bresp = 2'b11;
    resp_bad = 0; wait_bad = 0; timed_out = 0;
    while (!done) begin
      if (cyc >= 60) begin
        timed_out = 1;
        break;
      end
      awaddr  = addr;
      awvalid = !aw_done && (cyc >= aw_dly);
      wdata   = data;
      wstrb   = strb;
      wvalid  = !w_done && (cyc >= w_dly);
      bready  = 1'b0;
      @(negedge aclk);
      if (w_done && !aw_done && wready) wait_bad = 1;
      if (aw_done && !w_done && awready) wait_bad = 1;
      if (obs_hs >= 0 && cyc == obs_hs + 1) begin
        obs_we    = bram_we;
        obs_addr  = bram_addr;
        obs_wdata = bram_wdata;
      end else if (bram_we != 8'h00) begin
        stray_we++;
      end
      if (bvalid) begin
        obs_bcycles++;
        if (obs_b < 0) begin
          obs_b     = cyc;
          obs_bresp = bresp;
        end else if (bresp !== obs_bresp) begin
          resp_bad = 1;
        end
        if (awready || wready) resp_bad = 1;
        bready = (b_wait >= b_hold);
        b_wait++;
        if (bready) done = 1;
      end
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge aclk);
      #1;
      if (aw_now) aw_done = 1;
      if (w_now)  w_done  = 1;
      if ((aw_now || w_now) && aw_done && w_done && obs_hs < 0) obs_hs = cyc;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    total++; if (awready !== 1'b0) begin bad++; $display("[TB] FAIL reset_awready got=%b want=0", awready); end
    total++; if (wready !== 1'b0) begin bad++; $display("[TB] FAIL reset_wready got=%b want=0", wready); end
    total++; if (bvalid !== 1'b0 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL reset_b got=%b/%b want=0/00", bvalid, bresp); end
    total++; if (bram_we !== 8'h00) begin bad++; $display("[TB] FAIL reset_we got=%h want=00", bram_we); end
    total++; if (bram_addr !== 9'd0 || bram_wdata !== 64'd0) begin bad++; $display("[TB] FAIL reset_bram got=%h/%h want=0/0", bram_addr, bram_wdata); end
    total++; if (write_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", write_count); end
    @(posedge aclk);
    #1 areset = 1'b0;
    model_count = 0;
    @(negedge aclk);
    total++; if (awready !== 1'b1 || wready !== 1'b1) begin bad++; $display("[TB] FAIL idle_ready got=%b%b want=11", awready, wready); end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_same_cycle();
    run_write(32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0);
    model_count++;
    total++; if (timed_out) begin bad++; $display("[TB] FAIL same_timeout got=timeout want=response"); end
    total++; if (obs_we !== 8'hFF || obs_addr !== 9'd2) begin bad++; $display("[TB] FAIL same_we got=%h@%0d want=ff@2", obs_we, obs_addr); end
    total++; if (obs_wdata !== 64'h1122334455667788) begin bad++; $display("[TB] FAIL same_wdata got=%h want=1122334455667788", obs_wdata); end
    total++; if (obs_b !== obs_hs + 2 || obs_bresp !== 2'b00) begin bad++; $display("[TB] FAIL same_latency got=%0d/%b want=%0d/00", obs_b, obs_bresp, obs_hs + 2); end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL same_count got=%0d want=%0d", write_count, model_count); end
  endtask

  task automatic test_w_first();
    run_write(32'h8, 64'hCAFEF00DDEADBEEF, 8'h0F, 2, 0, 0);
    model_count++;
    total++; if (wait_bad) begin bad++; $display("[TB] FAIL wfirst_wready got=ready_high want=ready_low"); end
    total++; if (obs_hs !== 2) begin bad++; $display("[TB] FAIL wfirst_hs got=%0d want=2", obs_hs); end
    total++; if (obs_we !== 8'h0F || obs_addr !== 9'd1) begin bad++; $display("[TB] FAIL wfirst_we got=%h@%0d want=0f@1", obs_we, obs_addr); end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL wfirst_count got=%0d want=%0d", write_count, model_count); end
  endtask

  task automatic test_out_of_range();
    run_write(32'h1000, 64'h0123456789ABCDEF, 8'hFF, 0, 1, 0);
    total++; if (obs_we !== 8'h00 || stray_we !== 0) begin bad++; $display("[TB] FAIL oor_we got=%h stray=%0d want=00 stray=0", obs_we, stray_we); end
    total++; if (obs_bresp !== 2'b10) begin bad++; $display("[TB] FAIL oor_bresp got=%b want=10", obs_bresp); end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL oor_count got=%0d want=%0d", write_count, model_count); end
  endtask

  task automatic test_bready_stall();
    run_write(32'h18, 64'h5555AAAA5555AAAA, 8'h3C, 1, 0, 5);
    model_count++;
    total++; if (obs_bcycles !== 6) begin bad++; $display("[TB] FAIL stall_bvalid_cycles got=%0d want=6", obs_bcycles); end
    total++; if (resp_bad) begin bad++; $display("[TB] FAIL stall_hold got=unstable want=stable"); end
    total++; if (stray_we !== 0) begin bad++; $display("[TB] FAIL stall_stray_we got=%0d want=0", stray_we); end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL stall_count got=%0d want=%0d", write_count, model_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      bit          ok;
      a = 32'($urandom_range(0, 5119));
      d = {$urandom, $urandom};
      s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ok = (a < 32'd4096);
      run_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      if (ok && model_count < 65535) model_count++;
      total++;
      if (timed_out || obs_we !== (ok ? s : 8'h00) || obs_addr !== 9'(a / 8) ||
          obs_wdata !== d || obs_bresp !== (ok ? 2'b00 : 2'b10) ||
          obs_b !== obs_hs + 2 || stray_we !== 0 || resp_bad || wait_bad) begin
        bad++;
        $display("[TB] FAIL rand_%0d got we=%h addr=%0d data=%h resp=%b lat=%0d stray=%0d want we=%h addr=%0d data=%h resp=%b lat=2",
                 i, obs_we, obs_addr, obs_wdata, obs_bresp, obs_b - obs_hs, stray_we,
                 ok ? s : 8'h00, a / 8, d, ok ? 2'b00 : 2'b10);
      end
      total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL rand_count_%0d got=%0d want=%0d", i, write_count, model_count); end
    end
  endtask

  task automatic test_back_to_back();
    int start_cyc, end_cyc;
    start_cyc = int'($time / 10);
    for (int i = 0; i < 4; i++) begin
      run_write(32'(8 * i), 64'(i), 8'h01, 0, 0, 0);
      model_count++;
    end
    end_cyc = int'($time / 10);
    total++; if (end_cyc - start_cyc !== 12) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d want=12", end_cyc - start_cyc); end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", write_count, model_count); end
  endtask

  task automatic test_reset_in_resp();
    int n = 0;
    awaddr = 32'h20; wdata = 64'hFFFF0000FFFF0000; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 10) begin
      @(posedge aclk);
      #1 n++;
    end
    total++; if (bvalid !== 1'b1) begin bad++; $display("[TB] FAIL rst_resp_reach got=%b want=1", bvalid); end
    areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    model_count = 0;
    @(negedge aclk);
    total++; if (bvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_resp_bvalid got=%b want=0", bvalid); end
    total++; if (write_count !== 16'd0) begin bad++; $display("[TB] FAIL rst_resp_count got=%0d want=0", write_count); end
    repeat (2) @(negedge aclk);
    total++; if (bvalid !== 1'b0 || bram_we !== 8'h00) begin bad++; $display("[TB] FAIL rst_resp_quiet got=%b/%h want=0/00", bvalid, bram_we); end
    @(posedge aclk);
    #1;
    run_write(32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0);
    model_count++;
    total++; if (obs_we !== 8'hFF || obs_addr !== 9'd2 || obs_b !== obs_hs + 2 || obs_bresp !== 2'b00) begin
      bad++; $display("[TB] FAIL rst_after got=%h@%0d lat=%0d resp=%b want=ff@2 lat=2 resp=00", obs_we, obs_addr, obs_b - obs_hs, obs_bresp);
    end
    total++; if (write_count !== 16'(model_count)) begin bad++; $display("[TB] FAIL rst_after_count got=%0d want=%0d", write_count, model_count); end
  endtask

  initial begin
    areset = 1'b1; awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    #1;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_out_of_range();
    test_bready_stall();
    test_random();
    test_back_to_back();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
